// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide engine with architectural HI/LO.
// The result is computed when the operation is accepted and held in pending
// registers. It is committed to HI/LO after a fixed busy period, which
// matches the latency the hazard unit expects.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  moveto,
  input  logic [1:0]  movefrom,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;
  logic [31:0]       pend_hi_reg, pend_hi_next;
  logic [31:0]       pend_lo_reg, pend_lo_next;
  logic              pend_valid_reg, pend_valid_next;
  logic              done_reg, done_next;

  // Datapath: full-width products and quotients of the current operands.
  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        b_safe;
  logic signed [32:0] a_s33, b_s33, quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               is_div, div_by_zero;
  logic [63:0]        result;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};

  // A zero divisor is replaced by 1 so the dividers never see x; the
  // result is discarded anyway because pend_valid is cleared.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;

  // 33-bit signed division makes 0x80000000 / -1 yield +2^31, whose low
  // 32 bits are the architecturally required 0x80000000.
  assign a_s33  = {a[31], a};
  assign b_s33  = {b_safe[31], b_safe};
  assign quot_s = a_s33 / b_s33;
  assign rem_s  = a_s33 % b_s33;
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  assign is_div      = op[1];
  assign div_by_zero = is_div && (b == 32'd0);

  // Select the 64-bit {hi,lo} result for the requested operation.
  always_comb begin
    result = 64'd0;
    case (op)
      2'b00:   result = prod_s;
      2'b01:   result = prod_u;
      2'b10:   result = {rem_s[31:0], quot_s[31:0]};
      default: result = {rem_u, quot_u};
    endcase
  end

  // State and architectural registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      hi_reg         <= 32'd0;
      lo_reg         <= 32'd0;
      pend_hi_reg    <= 32'd0;
      pend_lo_reg    <= 32'd0;
      pend_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      pend_hi_reg    <= pend_hi_next;
      pend_lo_reg    <= pend_lo_next;
      pend_valid_reg <= pend_valid_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic: accept start (priority over moveto) in IDLE, count
  // down in RUN and commit on the last busy cycle.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    pend_hi_next    = pend_hi_reg;
    pend_lo_next    = pend_lo_reg;
    pend_valid_next = pend_valid_reg;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pend_hi_next    = result[63:32];
          pend_lo_next    = result[31:0];
          pend_valid_next = !div_by_zero;
          count_next      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_next      = RUN;
        end else begin
          if (moveto[1]) hi_next = a;
          if (moveto[0]) lo_next = a;
        end
      end
      default: begin
        if (count_reg == CNT_W'(1)) begin
          if (pend_valid_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
          done_next  = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
    endcase
  end

  assign busy     = (state_reg == RUN);
  assign md_stall = busy | start;
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign rdata    = movefrom[1] ? hi_reg : lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic model of HI/LO.
module tb_muldiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [1:0]  moveto = 2'b00;
  logic [1:0]  movefrom = 2'b00;
  logic        busy, md_stall, done;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .moveto(moveto), .movefrom(movefrom), .busy(busy), .md_stall(md_stall),
    .done(done), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted operation.
  task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (o)
      2'b00: begin p = sx * sy; hi_m = p[63:32]; lo_m = p[31:0]; end
      2'b01: begin p = ux * uy; hi_m = p[63:32]; lo_m = p[31:0]; end
      2'b10: if (y != 32'd0) begin
        q = sx / sy; r = sx % sy;
        p = q; lo_m = p[31:0];
        p = r; hi_m = p[31:0];
      end
      default: if (y != 32'd0) begin
        uq = ux / uy; ur = ux % uy;
        p = uq; lo_m = p[31:0];
        p = ur; hi_m = p[31:0];
      end
    endcase
  endtask

  // Wait out a run that has already been accepted; returns busy cycles seen.
  task automatic wait_busy(input int first, output int cyc);
    cyc = first;
    while (busy && cyc < 100) begin
      #1 chk("md_stall_busy", {31'b0, md_stall}, 32'd1);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input int n);
    chk({tag, "_cycles"}, cyc, n);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_hi"}, hi, hi_m);
    chk({tag, "_lo"}, lo, lo_m);
    $display("txn %s: cycles=%0d hi=%h lo=%h", tag, cyc, hi, lo);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] mt);
    int cyc;
    model_op(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; moveto = mt;
    #1 chk("md_stall_start", {31'b0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; moveto = 2'b00; op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
    wait_busy(0, cyc);
    check_result("op", cyc, o[1] ? DC : MC);
    movefrom = 2'b10;
    #1 chk("rdata_hi", rdata, hi_m);
    movefrom = 2'b01;
    #1 chk("rdata_lo", rdata, lo_m);
    movefrom = 2'b00;
    @(negedge clk);
    chk("done_once", {31'b0, done}, 32'd0);
  endtask

  task automatic do_move(input logic [1:0] mt, input logic [31:0] x);
    @(negedge clk);
    moveto = mt; a = x;
    if (mt[1]) hi_m = x;
    if (mt[0]) lo_m = x;
    @(negedge clk);
    moveto = 2'b00;
    chk("move_busy", {31'b0, busy}, 32'd0);
    chk("move_hi", hi, hi_m);
    chk("move_lo", lo, lo_m);
    $display("txn move mt=%b a=%h hi=%h lo=%h", mt, x, hi, lo);
  endtask

  initial begin
    int cyc;
    logic [1:0] ro;
    logic [31:0] ry;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_md_stall", {31'b0, md_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 2'b00);
    chk("tp_mult_hi", hi, 32'hFFFFFFFF);
    chk("tp_mult_lo", lo, 32'hFFFFFFFE);
    do_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 2'b00);
    chk("tp_multu_hi", hi, 32'h00000001);
    chk("tp_multu_lo", lo, 32'hFFFFFFFE);
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 2'b00);
    chk("tp_div_hi", hi, 32'hFFFFFFFF);
    chk("tp_div_lo", lo, 32'hFFFFFFFD);
    do_move(2'b10, 32'h11111111);
    do_move(2'b01, 32'h22222222);
    do_op(2'b11, 32'h00000007, 32'h00000000, 2'b00);
    chk("tp_div0_hi", hi, 32'h11111111);
    chk("tp_div0_lo", lo, 32'h22222222);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 2'b00);
    chk("tp_ovf_hi", hi, 32'h00000000);
    chk("tp_ovf_lo", lo, 32'h80000000);
    do_move(2'b10, 32'hDEADBEEF);
    movefrom = 2'b10;
    #1 chk("tp_mfhi", rdata, 32'hDEADBEEF);
    movefrom = 2'b00;
    do_move(2'b11, 32'h12345678);

    // start and moveto together: start wins
    do_op(2'b01, 32'h00010000, 32'h00010000, 2'b11);
    chk("start_beats_move_hi", hi, 32'h00000001);

    // second start and mtlo while busy are ignored
    model_op(2'b00, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'h55; b = 32'h1; moveto = 2'b11;
    #1 chk("ign_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; moveto = 2'b00;
    wait_busy(1, cyc);
    check_result("ignore", cyc, MC);
    @(negedge clk);
    chk("ignore_no_rerun", {31'b0, busy}, 32'd0);

    // back-to-back: new start in the done cycle
    model_op(2'b01, 32'hCAFEF00D, 32'h00001234);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hCAFEF00D; b = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    wait_busy(0, cyc);
    check_result("b2b_first", cyc, MC);
    start = 1'b1; op = 2'b11; a = 32'hCAFEF00D; b = 32'h00000100;
    #1 chk("b2b_md_stall", {31'b0, md_stall}, 32'd1);
    model_op(2'b11, 32'hCAFEF00D, 32'h00000100);
    @(negedge clk);
    start = 1'b0;
    wait_busy(0, cyc);
    check_result("b2b_second", cyc, DC);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DC + 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", {30'b0, done, busy}, 32'd0);
    end
    $display("txn reset-abort: hi=%h lo=%h", hi, lo);

    // randomized mix against the model
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(4) == 0) begin
        do_move(2'($urandom_range(1, 3)), $urandom);
      end else begin
        ro = 2'($urandom_range(3));
        ry = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
        do_op(ro, $urandom, ry, 2'b00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide engine with architectural HI/LO registers, placed in the EX stage.
- Executes mult/multu/div/divu, mthi/mtlo and mfhi/mflo as issued by the instruction decoder.
- Inputs come from the decoder's ALUctr[4] (start), ALUctr[1:0] (op), moveto and movefrom fields.
- Drives busy/stall information to the hazard unit, and HI/LO read data to the EX result mux.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (≥1)
DIV_CYCLES, 10, busy duration for div/divu (≥1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin mult/div this cycle (ALUctr[4])
op  input  2  00 mult, 01 multu, 10 div, 11 divu (ALUctr[1:0])
a  input  32  rs operand (dividend / multiplicand)
b  input  32  rt operand (divisor / multiplier)
moveto  input  2  [1] mthi, [0] mtlo: write a into HI / LO
movefrom  input  2  [1] mfhi, [0] mflo: select rdata source
busy  output  1  operation in flight
md_stall  output  1  busy | start, combinational; hazard unit stalls D-stage md-class instrs
done  output  1  one-cycle pulse on the cycle after results commit
hi  output  32  HI register
lo  output  32  LO register
rdata  output  32  movefrom[1] ? hi : lo (combinational; lo when movefrom==00)

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, counter=0, pending result=0. Takes effect immediately; any in-flight operation is discarded and HI/LO are not written.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE + start at posedge:
  - Latch operands and op; compute the 64-bit pending result.
  - Load counter with MULT_CYCLES or DIV_CYCLES; enter RUN.
- RUN:
  - Counter decrements each posedge.
  - At the posedge where counter==1: commit pending result to HI/LO, busy->0, done=1 for the following cycle, return to IDLE.
  - busy is high for exactly N cycles; HI/LO visible on the first cycle busy=0.
- mult: signed 32x32->64, {hi,lo}=product. multu: unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b==0, div or divu): full DIV_CYCLES busy, then HI/LO keep their pre-start values; done still pulses.
- mthi/mtlo in IDLE with start=0: write a into HI/LO at posedge, no busy. Both bits set: both written.
- Boundary rules:
  - start while busy: ignored; no restart, operands not relatched.
  - moveto while busy: ignored.
  - start and moveto in the same cycle: start wins, moveto dropped.
  - done coinciding with a new start in the same cycle: accepted (IDLE that cycle).
- rdata is a pure mux of the current registers. During busy it returns old HI/LO; correctness relies on md_stall.
- op is don't-care when start=0. Only HI/LO and the pending registers hold state.

Test Plan:
- Reset then mult a=0xFFFFFFFF, b=0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- multu with same operands -> hi=0x00000001, lo=0xFFFFFFFE; div a=0xFFFFFFF9(-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 with prior hi=0x11111111, lo=0x22222222 -> busy 10 cycles, HI/LO unchanged, done pulses; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0, rdata=0xDEADBEEF with movefrom=10. During a mult, mtlo and a second start -> both ignored; result equals the first mult.
- Start div, drop rst_n low at cycle 4 -> busy, hi, lo are 0 immediately; no done pulse after rst_n returns high.
- md_stall=1 in the start cycle and all busy cycles. Back-to-back start in the cycle busy falls -> accepted, new N-cycle run begins.
